// File: rtl/mem_word_adapter_pkg.sv
// Shared definitions for the word-to-byte memory adapter: lane geometry,
// FSM state encodings, the latched request record and a lane extraction helper.
package mem_word_adapter_pkg;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEL   = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    // Request fields captured at acceptance; byte enables live in their own
    // shrinking "lanes left" register inside the adapter.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } word_req_t;

    // Byte lane k of a 32-bit word (lane 0 = bits [7:0]).
    function automatic logic [LANE_W-1:0] lane_byte(input logic [31:0] word,
                                                     input logic [1:0]  k);
        return word[{k, 3'b000} +: LANE_W];
    endfunction

endpackage

// File: rtl/mem_word_adapter_if.sv
// Word request/response port of the adapter. The master drives requests
// (CPU/bus side); the slave is the adapter that answers them.
interface mem_word_adapter_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_word_adapter_lane_sel.sv
// Lowest-set-bit encoder over the remaining byte enables; lanes are always
// served in ascending order, so the lowest pending lane goes next.
module mem_lane_sel
    import mem_word_adapter_pkg::*;
(
    input  logic [NUM_LANES-1:0] bits,
    output logic [1:0]           lane,
    output logic                 any_set
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        lane    = 2'd0;
        any_set = |bits;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (bits[i]) begin
                lane = i[1:0];
            end
        end
    end

endmodule

// File: rtl/mem_word_adapter.sv
// Word memory adapter: accepts 32-bit read/write requests with byte enables,
// plays them out as byte transactions on the cellular-RAM controller's
// go/done handshake and reassembles read bytes into one word response.
module mem_word_adapter
    import mem_word_adapter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    mem_word_adapter_if.slave   req_if,
    output logic [31:0]         mem_addr,
    output logic [LANE_W-1:0]   mem_wdata,
    input  logic [LANE_W-1:0]   mem_rdata,
    output logic                mem_we,
    output logic                mem_go,
    input  logic                mem_done
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0]           state;
    word_req_t            req_q;
    logic [NUM_LANES-1:0] be_left;
    logic [1:0]           cur_lane;
    logic [31:0]          rdata_acc;
    logic [7:0]           tmo_cnt;
    logic                 ready_q;
    logic                 resp_valid_q;
    logic [31:0]          resp_rdata_q;
    logic                 resp_err_q;
    logic [1:0]           sel_lane;
    logic                 sel_any;
    logic [31:0]          rdata_merged;

    mem_lane_sel u_lane_sel (
        .bits    (be_left),
        .lane    (sel_lane),
        .any_set (sel_any)
    );

    // go is only ever high in ISSUE, so an idle controller can never see a second go.
    assign mem_go = (state == ST_ISSUE);

    assign req_if.req_ready  = ready_q;
    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_rdata = resp_rdata_q;
    assign req_if.resp_err   = resp_err_q;

    // Accumulated read word with the byte currently returned by the controller merged in.
    always_comb begin
        rdata_merged = rdata_acc;
        if (!req_q.we) begin
            rdata_merged[{cur_lane, 3'b000} +: LANE_W] = mem_rdata;
        end
    end

    // Request FSM: latch, select lane, issue, wait for done, respond; timeout aborts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            req_q        <= '0;
            be_left      <= '0;
            cur_lane     <= 2'd0;
            rdata_acc    <= '0;
            tmo_cnt      <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (req_if.req_valid && ready_q) begin
                        ready_q   <= 1'b0;
                        req_q     <= '{we: req_if.req_we, addr: req_if.req_addr,
                                       wdata: req_if.req_wdata};
                        be_left   <= req_if.req_be;
                        rdata_acc <= '0;
                        if (req_if.req_addr[1:0] != 2'b00) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state        <= ST_RESP;
                        end else if (req_if.req_be == '0) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= '0;
                            state        <= ST_RESP;
                        end else begin
                            state <= ST_SEL;
                        end
                    end
                end
                ST_SEL: begin
                    cur_lane          <= sel_lane;
                    mem_addr          <= req_q.addr + {30'd0, sel_lane};
                    mem_wdata         <= lane_byte(req_q.wdata, sel_lane);
                    mem_we            <= req_q.we;
                    be_left[sel_lane] <= 1'b0;
                    tmo_cnt           <= '0;
                    state             <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (!mem_done) begin
                        state <= ST_WAIT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= rdata_acc;
                        state        <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (mem_done) begin
                        rdata_acc <= rdata_merged;
                        if (sel_any) begin
                            state <= ST_SEL;
                        end else begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= rdata_merged;
                            state        <= ST_RESP;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= rdata_acc;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
